// File: rtl/pipe_stall_ctrl.sv
// rtl/pipe_stall_ctrl.sv - pipeline stall bus and multi-cycle EX sequencer for the 5-stage core
// Optional macro PIPE_STALL_CTRL_MUL_MC_EN: multiply also runs through the multi-cycle FSM.
module pipe_stall_ctrl #(
  parameter int DIV_CYCLES = 32,
  parameter int MUL_CYCLES = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       stallreq_id,
  input  logic       mc_start,
  input  logic       mc_kind,
  output logic [5:0] stall,
  output logic       mc_first,
  output logic       mc_step,
  output logic       mc_done,
  output logic       mc_busy,
  output logic [5:0] mc_cnt
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_BUSY,
    ST_DONE
  } state_t;

  localparam logic [5:0] STALL_NONE = 6'b000000;
  localparam logic [5:0] STALL_ID   = 6'b000111;
  localparam logic [5:0] STALL_EX   = 6'b001111;
  localparam logic [5:0] DIV_N      = 6'(DIV_CYCLES);
  localparam logic [5:0] MUL_N      = 6'(MUL_CYCLES);
  localparam logic [5:0] CNT_MAX    = 6'd63;

  state_t     state_q, state_d;
  logic [5:0] cnt_q, cnt_d;
  logic       kind_q, kind_d;
  logic [5:0] n_sel;
  logic       mc_accept;
  logic [5:0] stall_c;
  logic       first_c, step_c, done_c;

`ifdef PIPE_STALL_CTRL_MUL_MC_EN
  assign mc_accept = mc_start;
`else
  // Single-cycle multiply: only divides enter the FSM, so kind_q is always 1 here.
  assign mc_accept = mc_start & mc_kind;
`endif

  assign n_sel = kind_q ? DIV_N : MUL_N;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    kind_d  = kind_q;
    stall_c = STALL_NONE;
    first_c = 1'b0;
    step_c  = 1'b0;
    done_c  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (mc_accept) begin
          first_c = 1'b1;
          stall_c = STALL_EX;
          cnt_d   = 6'd0;
          kind_d  = mc_kind;
          state_d = ST_BUSY;
        end else if (stallreq_id) begin
          stall_c = STALL_ID;
        end
      end
      ST_BUSY: begin
        // EX holds the older instruction, so the load-use request is masked.
        step_c  = 1'b1;
        stall_c = STALL_EX;
        if (cnt_q != CNT_MAX) cnt_d = cnt_q + 6'd1;
        if (({1'b0, cnt_q} + 7'd1) == {1'b0, n_sel}) state_d = ST_DONE;
      end
      ST_DONE: begin
        // mc_start still belongs to the finishing instruction; do not restart.
        done_c  = 1'b1;
        if (stallreq_id) stall_c = STALL_ID;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= 6'd0;
      kind_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      kind_q  <= kind_d;
    end
  end

  // Reset forces every output low in the same cycle, whatever the inputs.
  assign stall    = rst ? STALL_NONE : stall_c;
  assign mc_first = ~rst & first_c;
  assign mc_step  = ~rst & step_c;
  assign mc_done  = ~rst & done_c;
  assign mc_busy  = ~rst & (state_q != ST_IDLE);
  assign mc_cnt   = rst ? 6'd0 : cnt_q;

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// tb/tb_pipe_stall_ctrl.sv - self-checking bench for pipe_stall_ctrl against a phase-count model
module tb_pipe_stall_ctrl;

  localparam int DIV_N = 32;
  localparam int MUL_N = 4;
`ifdef PIPE_STALL_CTRL_MUL_MC_EN
  localparam bit MUL_EN = 1'b1;
`else
  localparam bit MUL_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst, stallreq_id, mc_start, mc_kind;
  logic [5:0] stall, mc_cnt;
  logic       mc_first, mc_step, mc_done, mc_busy;

  int n_checks = 0;
  int n_fail   = 0;

  // Model: an op is a phase count since its start cycle; phases 1..N step, N+1 is done.
  bit m_active = 1'b0;
  int m_ph     = 0;
  int m_n      = 0;
  int m_cnt    = 0;

  pipe_stall_ctrl #(.DIV_CYCLES(DIV_N), .MUL_CYCLES(MUL_N)) dut (
    .clk(clk), .rst(rst), .stallreq_id(stallreq_id), .mc_start(mc_start), .mc_kind(mc_kind),
    .stall(stall), .mc_first(mc_first), .mc_step(mc_step), .mc_done(mc_done),
    .mc_busy(mc_busy), .mc_cnt(mc_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [5:0] obs, input logic [5:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=%b expected=%b at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic cycle(input bit r, input bit sid, input bit st, input bit k);
    logic [5:0] e_stall;
    bit e_first, e_step, e_done, e_busy;
    int e_cnt;
    @(negedge clk);
    rst = r; stallreq_id = sid; mc_start = st; mc_kind = k;
    #1;
    e_stall = 6'b0; e_first = 0; e_step = 0; e_done = 0;
    e_busy = !r && m_active;
    e_cnt  = r ? 0 : m_cnt;
    if (r) begin
      m_active = 0;
      m_cnt = 0;
    end else if (!m_active) begin
      if (st && (k || MUL_EN)) begin
        e_first = 1; e_stall = 6'b001111;
        m_active = 1; m_ph = 1; m_n = k ? DIV_N : MUL_N; m_cnt = 0;
      end else begin
        e_stall = sid ? 6'b000111 : 6'b0;
      end
    end else if (m_ph <= m_n) begin
      e_step = 1; e_stall = 6'b001111;
      m_cnt = m_ph; m_ph++;
    end else begin
      e_done = 1; e_stall = sid ? 6'b000111 : 6'b0;
      m_active = 0;
    end
    chk("stall", stall, e_stall);
    chk("mc_first", {5'b0, mc_first}, {5'b0, e_first});
    chk("mc_step", {5'b0, mc_step}, {5'b0, e_step});
    chk("mc_done", {5'b0, mc_done}, {5'b0, e_done});
    chk("mc_busy", {5'b0, mc_busy}, {5'b0, e_busy});
    chk("mc_cnt", mc_cnt, 6'(e_cnt));
  endtask

  initial begin
    bit st, k;
    rst = 1; stallreq_id = 0; mc_start = 0; mc_kind = 0;
    // Reset with active inputs must still give all-zero outputs.
    cycle(1, 1, 1, 1);
    cycle(1, 0, 0, 0);
    cycle(0, 0, 0, 0);
    // Load-use only.
    cycle(0, 1, 0, 0);
    cycle(0, 0, 0, 0);
    // Divide held, load-use during BUSY, load-use in the DONE cycle.
    cycle(0, 0, 1, 1);
    for (int i = 1; i <= DIV_N; i++) cycle(0, 1'($urandom_range(0, 1)), 1, 1'($urandom_range(0, 1)));
    cycle(0, 1, 1, 1);
    // Back-to-back: second start accepted the cycle after DONE.
    for (int i = 0; i <= DIV_N + 1; i++) cycle(0, 0, 1, 1);
    cycle(0, 0, 0, 0);
    // Reset mid-op, nothing resumes afterwards.
    for (int i = 0; i < 10; i++) cycle(0, 0, 1, 1);
    cycle(1, 0, 1, 1);
    for (int i = 0; i < 4; i++) cycle(0, 0, 0, 1);
    // Multiply start held across the op.
    for (int i = 0; i < MUL_N + 3; i++) cycle(0, 0, 1, 0);
    cycle(0, 1, 0, 0);
    // Randomized traffic.
    st = 0; k = 1;
    for (int i = 0; i < 2000; i++) begin
      if ($urandom_range(0, 7) == 0) st = ~st;
      if ($urandom_range(0, 15) == 0) k = ~k;
      cycle(($urandom_range(0, 99) == 0), ($urandom_range(0, 2) == 0), st, k);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
